// File: rtl/data_memory_unit_if.sv
// Request/response bus between the datapath and the data memory unit.
// The master issues load/store requests and the slave returns a Done/Err pulse.
interface data_memory_unit_if;
  logic        Req;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        DMWr;
  logic [2:0]  DMCtrl;
  logic        Ready;
  logic        Done;
  logic        Err;
  logic [31:0] DataRd;

  modport master (
    output Req, Address, WriteData, DMWr, DMCtrl,
    input  Ready, Done, Err, DataRd
  );

  modport slave (
    input  Req, Address, WriteData, DMWr, DMCtrl,
    output Ready, Done, Err, DataRd
  );
endinterface

// File: rtl/data_memory_unit.sv
// RV32I load/store data memory: one request in flight, IDLE -> ACCESS -> RESP.
// Synchronous word array with byte-lane writes and sign/zero-extended loads.
module data_memory_unit #(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS)
) (
  input logic               clk,
  input logic               rst,
  data_memory_unit_if.slave bus
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;

  logic [1:0]       state_q;
  logic [IDX_W+1:0] addr_q;
  logic [31:0]      wdata_q;
  logic             wr_q;
  logic [2:0]       ctrl_q;
  logic [31:0]      rd_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [IDX_W-1:0] idx;
  logic             illegal;
  logic             misaligned;
  logic             ok;
  logic [3:0]       be;
  logic [31:0]      wlanes;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [31:0]      load_data;

  // Upper address bits only alias the array; they are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^bus.Address[31:IDX_W+2];

  assign idx = addr_q[IDX_W+1:2];

  always_comb begin
    illegal    = (ctrl_q == 3'b011) || (ctrl_q == 3'b110) || (ctrl_q == 3'b111) ||
                 (wr_q && ctrl_q[2]);
    misaligned = ((ctrl_q[1:0] == 2'b01) && addr_q[0]) ||
                 ((ctrl_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
    ok         = !illegal && !misaligned;
  end

  always_comb begin
    be     = 4'b0000;
    wlanes = wdata_q;
    unique case (ctrl_q[1:0])
      2'b00: begin
        be     = 4'b0001 << addr_q[1:0];
        wlanes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be     = addr_q[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{wdata_q[15:0]}};
      end
      2'b10: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    byte_sel  = rd_q[8*addr_q[1:0] +: 8];
    half_sel  = addr_q[1] ? rd_q[31:16] : rd_q[15:0];
    load_data = 32'h0;
    case (ctrl_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_data = rd_q;
      3'b100:  load_data = {24'h0, byte_sel};
      3'b101:  load_data = {16'h0, half_sel};
      default: load_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      ctrl_q  <= '0;
      rd_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.Req) begin
            addr_q  <= bus.Address[IDX_W+1:0];
            wdata_q <= bus.WriteData;
            wr_q    <= bus.DMWr;
            ctrl_q  <= bus.DMCtrl;
            state_q <= StAccess;
          end
        end
        StAccess: begin
          if (ok) rd_q <= mem[idx];
          state_q <= StResp;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Array has no reset; a reset during ACCESS suppresses the pending store.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == StAccess) && ok && wr_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  always_comb begin
    bus.Ready  = (state_q == StIdle) && !rst;
    bus.Done   = (state_q == StResp) && !rst;
    bus.Err    = bus.Done && !ok;
    bus.DataRd = 32'h0;
    if (bus.Done && ok && !wr_q) bus.DataRd = load_data;
  end

endmodule

// File: tb/tb_data_memory_unit.sv
// Scoreboard bench for data_memory_unit: directed loads/stores push expected responses,
// a negedge monitor pops them on Done and also checks outputs stay zero otherwise.
module tb_data_memory_unit;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  data_memory_unit_if bus();

  data_memory_unit #(.DEPTH_WORDS(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every Done pops one expectation; outside Done, Err/DataRd must be 0.
  always @(negedge clk) begin
    if (bus.Done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got err=%0b data=%h, required no response",
                 bus.Err, bus.DataRd);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.Err !== e.err || bus.DataRd !== e.data || (cyc - e.acc + 1) != 2) begin
          errors++;
          $display("FAIL %s: got err=%0b data=%h latency=%0d, required err=%0b data=%h latency=2",
                   e.name, bus.Err, bus.DataRd, cyc - e.acc + 1, e.err, e.data);
        end
      end
    end else begin
      checks++;
      if (bus.Err !== 1'b0 || bus.DataRd !== 32'h0) begin
        errors++;
        $display("FAIL idle_outputs: got err=%0b data=%h, required err=0 data=0",
                 bus.Err, bus.DataRd);
      end
    end
  end

  task automatic wait_ready(output bit got);
    int n = 0;
    while (bus.Ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    got = (bus.Ready === 1'b1);
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got Ready=%0b, required 1 within 20 cycles", bus.Ready);
    end
  endtask

  task automatic drive(input logic wr, input logic [2:0] ctrl, input logic [31:0] addr,
                       input logic [31:0] wd);
    bus.DMWr      = wr;
    bus.DMCtrl    = ctrl;
    bus.Address   = addr;
    bus.WriteData = wd;
  endtask

  task automatic issue(input string name, input logic wr, input logic [2:0] ctrl,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic exp_err, input logic [31:0] exp_data);
    bit   got;
    exp_t e;
    wait_ready(got);
    if (got) begin
      drive(wr, ctrl, addr, wd);
      bus.Req = 1'b1;
      e.err  = exp_err;
      e.data = exp_data;
      e.acc  = cyc + 1;
      e.name = name;
      sb.push_back(e);
      @(negedge clk);
      bus.Req = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (bus.Ready !== 1'b0 || bus.Done !== 1'b0 || bus.Err !== 1'b0 || bus.DataRd !== 32'h0) begin
      errors++;
      $display("FAIL %s: got Ready=%0b Done=%0b Err=%0b DataRd=%h, required all 0",
               name, bus.Ready, bus.Done, bus.Err, bus.DataRd);
    end
  endtask

  initial begin
    bit   got;
    logic pattern [6];
    int   n;
    pattern = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    cyc    = 0;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    bus.Req = 1'b0;
    drive(1'b0, 3'b010, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_outputs");
    rst = 1'b0;
    @(negedge clk);

    // Word round trip
    issue("sw_10",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    issue("lw_10",  1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF);

    // Byte/half extension on 0x80FF7F01
    issue("sw_20",  1'b1, 3'b010, 32'h20, 32'h80FF7F01, 1'b0, 32'h0);
    issue("lb_23",  1'b0, 3'b000, 32'h23, 32'h0, 1'b0, 32'hFFFFFF80);
    issue("lbu_23", 1'b0, 3'b100, 32'h23, 32'h0, 1'b0, 32'h00000080);
    issue("lh_20",  1'b0, 3'b001, 32'h20, 32'h0, 1'b0, 32'h00007F01);
    issue("lh_22",  1'b0, 3'b001, 32'h22, 32'h0, 1'b0, 32'hFFFF80FF);
    issue("lhu_22", 1'b0, 3'b101, 32'h22, 32'h0, 1'b0, 32'h000080FF);
    issue("lb_20",  1'b0, 3'b000, 32'h20, 32'h0, 1'b0, 32'h00000001);
    issue("lbu_21", 1'b0, 3'b100, 32'h21, 32'h0, 1'b0, 32'h0000007F);
    issue("lb_22",  1'b0, 3'b000, 32'h22, 32'h0, 1'b0, 32'hFFFFFFFF);

    // Partial stores
    issue("sw_30",  1'b1, 3'b010, 32'h30, 32'h11223344, 1'b0, 32'h0);
    issue("sb_31",  1'b1, 3'b000, 32'h31, 32'h000000AA, 1'b0, 32'h0);
    issue("sh_32",  1'b1, 3'b001, 32'h32, 32'h0000BEEF, 1'b0, 32'h0);
    issue("lw_30",  1'b0, 3'b010, 32'h30, 32'h0, 1'b0, 32'hBEEFAA44);

    // Misaligned / illegal never touch memory
    issue("sw_40",     1'b1, 3'b010, 32'h40, 32'h55667788, 1'b0, 32'h0);
    issue("sw_42_mis", 1'b1, 3'b010, 32'h42, 32'hFFFFFFFF, 1'b1, 32'h0);
    issue("lw_40_a",   1'b0, 3'b010, 32'h40, 32'h0, 1'b0, 32'h55667788);
    issue("ld_011",    1'b0, 3'b011, 32'h40, 32'h0, 1'b1, 32'h0);
    issue("sh_41_mis", 1'b1, 3'b001, 32'h41, 32'hFFFFFFFF, 1'b1, 32'h0);
    issue("lh_41_mis", 1'b0, 3'b001, 32'h41, 32'h0, 1'b1, 32'h0);
    issue("lw_42_mis", 1'b0, 3'b010, 32'h42, 32'h0, 1'b1, 32'h0);
    issue("sbu_ill",   1'b1, 3'b100, 32'h40, 32'hFFFFFFFF, 1'b1, 32'h0);
    issue("st_111",    1'b1, 3'b111, 32'h40, 32'hFFFFFFFF, 1'b1, 32'h0);
    issue("lw_40_b",   1'b0, 3'b010, 32'h40, 32'h0, 1'b0, 32'h55667788);

    // Address wrap modulo 4 KiB
    issue("sw_1004", 1'b1, 3'b010, 32'h00001004, 32'h12345678, 1'b0, 32'h0);
    issue("lw_0004", 1'b0, 3'b010, 32'h00000004, 32'h0, 1'b0, 32'h12345678);

    // Req held high: Ready 1,0,0,1,0,0; inputs changed during ACCESS are ignored
    wait_ready(got);
    if (got) begin
      drive(1'b0, 3'b010, 32'h10, 32'h0);
      bus.Req = 1'b1;
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (bus.Ready !== pattern[i]) begin
          errors++;
          $display("FAIL ready_pattern[%0d]: got %0b, required %0b", i, bus.Ready, pattern[i]);
        end
        if (bus.Ready === 1'b1) begin
          exp_t e;
          e.err  = 1'b0;
          e.data = 32'hDEADBEEF;
          e.acc  = cyc + 1;
          e.name = "lw_10_held";
          sb.push_back(e);
        end
        if (i == 1 || i == 4) drive(1'b1, 3'b010, 32'h20, 32'h0);
        if (i == 2) drive(1'b0, 3'b010, 32'h10, 32'h0);
        @(negedge clk);
      end
      bus.Req = 1'b0;
    end
    issue("lw_20_after", 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'h80FF7F01);

    // Reset during ACCESS drops the store and its response
    issue("sw_50", 1'b1, 3'b010, 32'h50, 32'h0BADF00D, 1'b0, 32'h0);
    wait_ready(got);
    if (got) begin
      drive(1'b1, 3'b010, 32'h50, 32'hCAFEF00D);
      bus.Req = 1'b1;
      @(negedge clk);
      bus.Req = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("midop_reset_1");
      @(negedge clk);
      check_reset_outputs("midop_reset_2");
      rst = 1'b0;
      @(negedge clk);
    end
    issue("lw_50", 1'b0, 3'b010, 32'h50, 32'h0, 1'b0, 32'h0BADF00D);

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d responses outstanding, required 0", sb.size());
    end
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_unit.md
Name: data_memory_unit

Overview:
Load/store data memory that consumes the ALU result as its byte address, directly downstream of the ALU in the RISC-V datapath.
- Executes RV32I LB/LH/LW/LBU/LHU/SB/SH/SW through a Req/Ready request handshake.
- Reads the internal word array synchronously, with a fixed response latency.
- Checks alignment and operation encoding.
- Returns sign- or zero-extended load data with a Done/Err response pulse.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two, at least 4.
IDX_W, $clog2(DEPTH_WORDS), word-index width; derived, not overridden.

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous reset, active high
Req  input  1  request valid; sampled only while Ready=1
Address  input  32  byte address (ALU result)
WriteData  input  32  store data (rs2 value)
DMWr  input  1  1 = store, 0 = load
DMCtrl  input  3  funct3: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned
Ready  output  1  block idle, request will be accepted this cycle
Done  output  1  one-cycle response pulse
Err  output  1  valid with Done; misaligned or illegal access
DataRd  output  32  load result; valid with Done

Behaviour:
- Reset: while rst=1, Ready=0, Done=0, Err=0, DataRd=0, and the FSM goes to IDLE. Array contents are not cleared.
- FSM states are IDLE, ACCESS and RESP. Ready=1 only in IDLE with rst=0.
- IDLE: when Req=1, the request is accepted at the edge. Address, WriteData, DMWr and DMCtrl are latched and the FSM goes to ACCESS. Req=0 stays in IDLE.
- Input changes after acceptance have no effect.
- Request validity is checked on the latched fields:
  - Illegal: DMCtrl is 011, 110 or 111; or DMCtrl is 110/111 with DMWr=1; or a store with DMCtrl 100/101.
  - Misaligned: half-word access with Address[0]=1, or word access with Address[1:0]≠00.
  - In either case the array is neither read nor written.
- ACCESS (exactly one cycle):
  - At the closing edge the array word at index Address[IDX_W+1:2] is read into the response register. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS bytes.
  - A valid store writes at the same edge. Byte store writes lane Address[1:0] with WriteData[7:0]. Half store writes lane pair Address[1] with WriteData[15:0]. Word store writes all four lanes. Other lanes are unchanged.
  - Then go to RESP.
- RESP (exactly one cycle): Done=1, and Err=1 if the request was illegal or misaligned. Then go to IDLE.
  - Load OK: DataRd holds the selected byte or half, sign-extended for 000/001 and zero-extended for 100/101, or the full word for 010.
  - Store OK: DataRd=0.
  - Err: DataRd=0.
- Done, Err and DataRd are 0 in every cycle other than RESP.
- Latency: Done is asserted 2 cycles after the accepting edge. Ready re-asserts the cycle after RESP, so throughput is 1 request per 3 cycles.
- Reset mid-operation: rst=1 during ACCESS suppresses the pending write, clears the latched request and produces no Done.
- Read of a word just written: a load accepted after a store's RESP sees the new data. No hazard exists because only one request is ever in flight.
- Illegal/misaligned with DMWr=1 never modifies memory.

Test Plan:
- Word round trip: SW Address=0x10, WriteData=0xDEADBEEF; then LW 0x10 -> Done 2 cycles after each accept, Err=0, DataRd=0xDEADBEEF.
- Byte/half extension: memory word at 0x20 is 0x80FF7F01. Expected results:
  - LB 0x23 -> 0xFFFFFF80
  - LBU 0x23 -> 0x00000080
  - LH 0x20 -> 0x00007F01
  - LH 0x22 -> 0xFFFF80FF
  - LHU 0x22 -> 0x000080FF
- Partial stores: word 0x30 holds 0x11223344. SB 0x31 with data 0xAA, then SH 0x32 with data 0xBEEF, then LW 0x30 -> 0xBEEFAA44.
- Misaligned/illegal:
  - SW 0x42 with data 0xFFFFFFFF -> Done=1, Err=1, DataRd=0. A following LW 0x40 returns the prior contents.
  - DMCtrl=011 load -> Err=1.
  - SH 0x41 -> Err=1.
- Wrap and handshake, with DEPTH_WORDS=1024:
  - SW 0x00001004 with data 0x12345678, then LW 0x00000004 -> 0x12345678.
  - Req held high continuously -> Ready pattern 1,0,0,1,0,0, one accept per 3 cycles.
  - Input changes during ACCESS are ignored.
- Reset mid-op: SW 0x50 with data 0xCAFEF00D, assert rst in the ACCESS cycle -> no Done. All outputs 0 during reset. After release, LW 0x50 returns the old value.
